adsr_vca: RTL and testbench

ADSR_VCA -- requirements
Module: adsr_vca

---
 rtl/adsr_vca.sv | 83 ++++++++
 tb/tb_adsr_vca.sv | 98 +++++++++
 2 files changed

// File: rtl/adsr_vca.sv
// adsr_vca: ADSR envelope generator driving a VCA. Ports: clk, rst (sync, active-high), tick (envelope strobe), gate (key held), sample_in[M], attack/decay/release_step[E], sustain_level[E] -> sample_out[M], env_out[E], state_out[2:0], active.
module adsr_vca #(
  parameter int M = 12,
  parameter int E = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         gate,
  input  logic [M-1:0] sample_in,
  input  logic [E-1:0] attack_step,
  input  logic [E-1:0] decay_step,
  input  logic [E-1:0] release_step,
  input  logic [E-1:0] sustain_level,
  output logic [M-1:0] sample_out,
  output logic [E-1:0] env_out,
  output logic [2:0]   state_out,
  output logic         active
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } state_t;
  localparam logic [E:0] MAXV = {1'b0, {E{1'b1}}};
  state_t state, state_n;
  logic [E-1:0] env, env_n;
  logic gate_q;
  logic rise, dec_hit, rel_hit;
  logic [E:0] sum;
  logic [M+E-1:0] prod;
  assign rise = gate & ~gate_q;
  assign sum = {1'b0, env} + {1'b0, attack_step};
  assign dec_hit = (env <= sustain_level) || (decay_step >= env - sustain_level);
  assign rel_hit = release_step >= env;
  assign prod = {{E{1'b0}}, sample_in} * {{M{1'b0}}, env};
  always_comb begin
    state_n = state;
    env_n = env;
    if (state > RELEASE) begin
      state_n = IDLE;
      env_n = '0;
    end else if (rise) state_n = ATTACK;
    else if (!gate && state inside {ATTACK, DECAY, SUSTAIN}) state_n = RELEASE;
    else if (tick) begin
      case (state)
        IDLE: env_n = '0;
        ATTACK: begin
          env_n = sum[E] ? {E{1'b1}} : sum[E-1:0];
          state_n = (sum >= MAXV) ? DECAY : ATTACK;
        end
        DECAY: begin
          env_n = dec_hit ? sustain_level : env - decay_step;
          state_n = dec_hit ? SUSTAIN : DECAY;
        end
        SUSTAIN: env_n = sustain_level;
        RELEASE: begin
          env_n = rel_hit ? '0 : env - release_step;
          state_n = rel_hit ? IDLE : RELEASE;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      env <= '0;
      gate_q <= 1'b0;
      sample_out <= '0;
    end else begin
      state <= state_n;
      env <= env_n;
      gate_q <= gate;
      sample_out <= prod[M+E-1:E];
    end
  end
  assign env_out = env;
  assign state_out = state;
  assign active = state != IDLE;
endmodule

// File: tb/tb_adsr_vca.sv
// tb_adsr_vca: directed self-checking bench for adsr_vca.
module tb_adsr_vca;
  logic clk = 0, rst = 1, tick = 0, gate = 0;
  logic [11:0] sample_in = 0, attack_step = 0, decay_step = 0, release_step = 0, sustain_level = 0;
  logic [11:0] sample_out, env_out;
  logic [2:0] state_out;
  logic active;
  int total = 0, bad = 0;
  adsr_vca dut (
    .clk(clk), .rst(rst), .tick(tick), .gate(gate), .sample_in(sample_in),
    .attack_step(attack_step), .decay_step(decay_step), .release_step(release_step),
    .sustain_level(sustain_level), .sample_out(sample_out), .env_out(env_out),
    .state_out(state_out), .active(active)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_es(input string tag, input int e, input int s);
    chk({tag, "_env"}, int'(env_out), e);
    chk({tag, "_state"}, int'(state_out), s);
  endtask
  initial begin
    int e;
    step();
    step();
    chk_es("rst", 0, 0);
    chk("rst_active", int'(active), 0);
    chk("rst_sample", int'(sample_out), 0);
    rst = 0;
    step();
    chk_es("idle", 0, 0);
    tick = 1; attack_step = 1024; decay_step = 512; sustain_level = 2048; sample_in = 4000;
    gate = 1;
    step(); chk_es("att_entry", 0, 1); chk("att_active", int'(active), 1);
    step(); chk_es("att1", 1024, 1);
    step(); chk_es("att2", 2048, 1);
    step(); chk_es("att3", 3072, 1);
    step(); chk_es("att_top", 4095, 2);
    step(); chk_es("dec1", 3583, 2); chk("scale_full", int'(sample_out), 3999);
    step(); chk_es("dec2", 3071, 2);
    step(); chk_es("dec3", 2559, 2);
    step(); chk_es("dec_sus", 2048, 3); chk("scale_2559", int'(sample_out), 2499);
    step(); chk_es("sus", 2048, 3); chk("scale_2048", int'(sample_out), 2000);
    sustain_level = 1500;
    step(); chk_es("sus_track", 1500, 3);
    sustain_level = 2048;
    step(); chk_es("sus_back", 2048, 3);
    release_step = 1000; gate = 0;
    step(); chk_es("rel_hold", 2048, 4);
    step(); chk_es("rel1", 1048, 4);
    step(); chk_es("rel2", 48, 4);
    step(); chk_es("rel_end", 0, 0); chk("rel_active", int'(active), 0);
    step(); chk_es("idle2", 0, 0); chk("scale_zero", int'(sample_out), 0);
    attack_step = 4095; decay_step = 2047; gate = 1;
    step(); chk_es("rt_att", 0, 1);
    step(); chk_es("rt_top", 4095, 2);
    step(); chk_es("rt_sus", 2048, 3);
    release_step = 548; gate = 0;
    step(); chk_es("rt_relh", 2048, 4);
    step(); chk_es("rt_rel", 1500, 4);
    attack_step = 1024; gate = 1;
    step(); chk_es("retrig_hold", 1500, 1);
    step(); chk_es("retrig_att", 2524, 1);
    attack_step = 100; e = 2524;
    for (int i = 0; i < 8; i++) begin
      tick = (i % 4 == 3);
      if (tick) e += 100;
      step(); chk_es("tickgate", e, 1);
    end
    tick = 1; attack_step = 1371; decay_step = 1095;
    step(); chk_es("pre_rst_top", 4095, 2);
    step(); chk_es("pre_rst_dec", 3000, 2);
    rst = 1;
    step(); chk_es("mid_rst", 0, 0); chk("mid_rst_sample", int'(sample_out), 0); chk("mid_rst_active", int'(active), 0);
    rst = 0; attack_step = 4095; decay_step = 1000;
    step(); chk_es("post_rst_att", 0, 1);
    step(); chk_es("p_top", 4095, 2);
    step(); chk_es("p_dec", 3095, 2);
    sustain_level = 3500;
    step(); chk_es("sus_above", 3500, 3);
    release_step = 0; gate = 0;
    step(); chk_es("z_relh", 3500, 4);
    step(); chk_es("z_rel", 3500, 4);
    release_step = 4000;
    step(); chk_es("big_rel", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
